// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared constants for the CDB write-back arbiter
package cdb_arbiter_pkg;

    localparam int DEF_N_REQ         = 2;
    localparam int DEF_ROB_INDEX_BIT = 4;
    localparam int DEF_DATA_W        = 32;
    localparam int DEF_FIFO_DEPTH    = 2;

    // Requester slots on the CDB
    localparam int CDB_SRC_RS  = 0;
    localparam int CDB_SRC_LSB = 1;

    // Width of a requester index; a single requester still gets one bit
    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - producer-side and broadcast-side bundle of the CDB arbiter
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ         = DEF_N_REQ,
    parameter int ROB_INDEX_BIT = DEF_ROB_INDEX_BIT,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int SRC_W         = src_width(N_REQ)
);

    logic [N_REQ-1:0]               req_valid;
    logic [N_REQ*ROB_INDEX_BIT-1:0] req_rob_id;
    logic [N_REQ*DATA_W-1:0]        req_val;
    logic [N_REQ-1:0]               req_ready;
    logic                           cdb_valid;
    logic [ROB_INDEX_BIT-1:0]       cdb_rob_id;
    logic [DATA_W-1:0]              cdb_val;
    logic [SRC_W-1:0]               cdb_src;
    logic                           busy_out;

    // Producers and CDB consumers
    modport master (
        output req_valid, req_rob_id, req_val,
        input  req_ready, cdb_valid, cdb_rob_id, cdb_val, cdb_src, busy_out
    );

    // The arbiter itself
    modport slave (
        input  req_valid, req_rob_id, req_val,
        output req_ready, cdb_valid, cdb_rob_id, cdb_val, cdb_src, busy_out
    );

endinterface

// File: rtl/cdb_req_fifo.sv
// rtl/cdb_req_fifo.sv - small per-requester result FIFO with flush
module cdb_req_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 36,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // Pointer/count update; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk_in) begin
        if (rst_in || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= wdata;
                tail      <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[head];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter sharing the CDB between result producers
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ         = DEF_N_REQ,
    parameter int ROB_INDEX_BIT = DEF_ROB_INDEX_BIT,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          clear_in,
    cdb_arbiter_if.slave  bus
);

    localparam int SRC_W = src_width(N_REQ);
    localparam int ENT_W = ROB_INDEX_BIT + DATA_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [ENT_W-1:0] head_ent   [N_REQ];
    logic [CNT_W-1:0] fifo_count [N_REQ];
    logic [N_REQ-1:0] full;
    logic [N_REQ-1:0] empty;
    logic [N_REQ-1:0] push;
    logic [N_REQ-1:0] pop;

    logic             grant_valid;
    logic [SRC_W-1:0] grant_idx;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] rr_next;
    logic [ENT_W-1:0] win_ent;
    logic             any_pending;

    logic                     cdb_valid_q;
    logic [ROB_INDEX_BIT-1:0] cdb_rob_id_q;
    logic [DATA_W-1:0]        cdb_val_q;
    logic [SRC_W-1:0]         cdb_src_q;

    // Only accepted, non-flushed edges touch the FIFOs
    for (genvar i = 0; i < N_REQ; i++) begin : g_fifo
        assign push[i] = rdy_in && !clear_in && bus.req_valid[i] && !full[i];
        assign pop[i]  = rdy_in && !clear_in && grant_valid && (grant_idx == SRC_W'(i));

        cdb_req_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (ENT_W)
        ) u_fifo (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .flush  (clear_in),
            .push   (push[i]),
            .pop    (pop[i]),
            .wdata  ({bus.req_rob_id[i*ROB_INDEX_BIT +: ROB_INDEX_BIT],
                      bus.req_val[i*DATA_W +: DATA_W]}),
            .rdata  (head_ent[i]),
            .count  (fifo_count[i]),
            .full   (full[i]),
            .empty  (empty[i])
        );
    end

    // Round-robin pick: first non-empty FIFO at or after rr_ptr
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!grant_valid && !empty[SRC_W'(idx)]) begin
                grant_valid = 1'b1;
                grant_idx   = SRC_W'(idx);
            end
        end
        rr_next = SRC_W'((int'(grant_idx) + 1) % N_REQ);
        win_ent = head_ent[grant_idx];
    end

    // Any result still queued keeps the block busy
    always_comb begin
        any_pending = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (fifo_count[i] != '0) begin
                any_pending = 1'b1;
            end
        end
    end

    // Registered broadcast and round-robin pointer; clear behaves like reset
    always_ff @(posedge clk_in) begin
        if (rst_in || clear_in) begin
            cdb_valid_q  <= 1'b0;
            cdb_rob_id_q <= '0;
            cdb_val_q    <= '0;
            cdb_src_q    <= '0;
            rr_ptr       <= '0;
        end else if (rdy_in) begin
            if (grant_valid) begin
                cdb_valid_q  <= 1'b1;
                cdb_rob_id_q <= win_ent[ENT_W-1 -: ROB_INDEX_BIT];
                cdb_val_q    <= win_ent[DATA_W-1:0];
                cdb_src_q    <= grant_idx;
                rr_ptr       <= rr_next;
            end else begin
                cdb_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = ~full;
    assign bus.cdb_valid  = cdb_valid_q;
    assign bus.cdb_rob_id = cdb_rob_id_q;
    assign bus.cdb_val    = cdb_val_q;
    assign bus.cdb_src    = cdb_src_q;
    assign bus.busy_out   = any_pending || cdb_valid_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic clear_in;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_in = ~clk_in;

    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .clear_in (clear_in),
        .bus      (bus)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [3:0] id0, input logic [31:0] val0,
                         input logic [3:0] id1, input logic [31:0] val1);
        bus.req_valid  = v;
        bus.req_rob_id = {id1, id0};
        bus.req_val    = {val1, val0};
    endtask

    task automatic check_out(input string tag, input logic [3:0] id, input logic [31:0] val,
                             input logic src, input logic [1:0] ready, input logic busy);
        check({tag, "_valid"}, 32'(bus.cdb_valid), 32'd1);
        check({tag, "_id"},    32'(bus.cdb_rob_id), 32'(id));
        check({tag, "_val"},   bus.cdb_val, val);
        check({tag, "_src"},   32'(bus.cdb_src), 32'(src));
        check({tag, "_ready"}, 32'(bus.req_ready), 32'(ready));
        check({tag, "_busy"},  32'(bus.busy_out), 32'(busy));
    endtask

    task automatic check_idle(input string tag, input logic [1:0] ready, input logic busy);
        check({tag, "_valid"}, 32'(bus.cdb_valid), 32'd0);
        check({tag, "_ready"}, 32'(bus.req_ready), 32'(ready));
        check({tag, "_busy"},  32'(bus.busy_out), 32'(busy));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"}, 32'(bus.cdb_valid), 32'd0);
        check({tag, "_id"},    32'(bus.cdb_rob_id), 32'd0);
        check({tag, "_val"},   bus.cdb_val, 32'd0);
        check({tag, "_src"},   32'(bus.cdb_src), 32'd0);
        check({tag, "_ready"}, 32'(bus.req_ready), 32'h3);
        check({tag, "_busy"},  32'(bus.busy_out), 32'd0);
    endtask

    initial begin
        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        clear_in = 1'b0;
        drive(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        tick();
        tick();
        rst_in = 1'b0;
        check_cleared("reset");
        tick();
        check_idle("reset_idle", 2'b11, 1'b0);

        // Contention with rr_ptr = 0: RS first, then LSB
        drive(2'b11, 4'd3, 32'd10, 4'd7, 32'd20);
        tick();
        drive(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        check_idle("cont_acc", 2'b11, 1'b1);
        tick();
        check_out("cont_g0", 4'd3, 32'd10, CDB_SRC_RS[0], 2'b11, 1'b1);
        tick();
        check_out("cont_g1", 4'd7, 32'd20, CDB_SRC_LSB[0], 2'b11, 1'b1);
        tick();
        check_idle("cont_end", 2'b11, 1'b0);

        // Single result, two-edge latency, one-cycle pulse
        drive(2'b01, 4'd5, 32'h1234, 4'd0, 32'd0);
        tick();
        drive(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        check_idle("single_acc", 2'b11, 1'b1);
        tick();
        check_out("single", 4'd5, 32'h1234, 1'b0, 2'b11, 1'b1);
        tick();
        check_idle("single_end", 2'b11, 1'b0);
        check("single_hold_id", 32'(bus.cdb_rob_id), 32'd5);

        // Back-pressure on FIFO1 (rr_ptr = 1 now); B3 is held until accepted
        drive(2'b11, 4'd1, 32'h101, 4'd8, 32'h108);
        tick();
        check_idle("bp_e1", 2'b11, 1'b1);
        drive(2'b11, 4'd2, 32'h102, 4'd9, 32'h109);
        tick();
        check_out("bp_e2", 4'd8, 32'h108, 1'b1, 2'b10, 1'b1);
        drive(2'b10, 4'd0, 32'd0, 4'd10, 32'h10a);
        tick();
        check_out("bp_e3", 4'd1, 32'h101, 1'b0, 2'b01, 1'b1);
        drive(2'b10, 4'd0, 32'd0, 4'd11, 32'h10b);
        tick();
        check_out("bp_e4", 4'd9, 32'h109, 1'b1, 2'b11, 1'b1);
        tick();
        check_out("bp_e5", 4'd2, 32'h102, 1'b0, 2'b01, 1'b1);
        drive(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        tick();
        check_out("bp_e6", 4'd10, 32'h10a, 1'b1, 2'b11, 1'b1);
        tick();
        check_out("bp_e7", 4'd11, 32'h10b, 1'b1, 2'b11, 1'b1);
        tick();
        check_idle("bp_end", 2'b11, 1'b0);

        // Flush with three entries pending and a push in the same edge
        drive(2'b11, 4'd4, 32'h104, 4'd12, 32'h10c);
        tick();
        check_idle("fl_acc", 2'b11, 1'b1);
        drive(2'b11, 4'd5, 32'h105, 4'd13, 32'h10d);
        tick();
        check_out("fl_pre", 4'd4, 32'h104, 1'b0, 2'b01, 1'b1);
        drive(2'b01, 4'd6, 32'h106, 4'd0, 32'd0);
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        drive(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        check_cleared("flush");
        tick();
        check_idle("fl_quiet1", 2'b11, 1'b0);
        tick();
        check_idle("fl_quiet2", 2'b11, 1'b0);
        drive(2'b11, 4'd14, 32'h10e, 4'd15, 32'h10f);
        tick();
        drive(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        check_idle("fl_rr_acc", 2'b11, 1'b1);
        tick();
        check_out("fl_rr0", 4'd14, 32'h10e, 1'b0, 2'b11, 1'b1);
        tick();
        check_out("fl_rr1", 4'd15, 32'h10f, 1'b1, 2'b11, 1'b1);
        tick();
        check_idle("fl_rr_end", 2'b11, 1'b0);

        // Reset in the middle of traffic
        drive(2'b01, 4'd1, 32'h201, 4'd0, 32'd0);
        tick();
        drive(2'b01, 4'd2, 32'h202, 4'd0, 32'd0);
        tick();
        check_out("rst_pre", 4'd1, 32'h201, 1'b0, 2'b11, 1'b1);
        rst_in = 1'b1;
        drive(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        tick();
        rst_in = 1'b0;
        check_cleared("rst_mid");
        tick();
        check_idle("rst_quiet1", 2'b11, 1'b0);
        tick();
        check_idle("rst_quiet2", 2'b11, 1'b0);

        // Pause: rdy_in low freezes everything and ignores pushes
        drive(2'b11, 4'd3, 32'h300, 4'd7, 32'h307);
        tick();
        drive(2'b01, 4'd8, 32'h308, 4'd0, 32'd0);
        tick();
        check_out("pause_pre", 4'd3, 32'h300, 1'b0, 2'b11, 1'b1);
        rdy_in = 1'b0;
        drive(2'b10, 4'd0, 32'd0, 4'd9, 32'h309);
        tick();
        check_out("pause1", 4'd3, 32'h300, 1'b0, 2'b11, 1'b1);
        tick();
        check_out("pause2", 4'd3, 32'h300, 1'b0, 2'b11, 1'b1);
        tick();
        check_out("pause3", 4'd3, 32'h300, 1'b0, 2'b11, 1'b1);
        rdy_in = 1'b1;
        drive(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
        tick();
        check_out("resume0", 4'd7, 32'h307, 1'b1, 2'b11, 1'b1);
        tick();
        check_out("resume1", 4'd8, 32'h308, 1'b0, 2'b11, 1'b1);
        tick();
        check_idle("resume_end", 2'b11, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
